c1_bus_master: RTL and testbench

//  Synthesizable CPU-side master for the C1 (CPU<->cache) bus.

---
 rtl/c1_bus_master.sv | 180 ++++++++++++++++++
 tb/tb_c1_bus_master.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/c1_bus_master.sv
// CPU-side C1 bus master: one core request at a time, split address phase, turnaround, response wait.
// Latency: resp_valid 4 cycles after accept (R32: 5), +1 per slave wait cycle; timeout after TIMEOUT_CYCLES.
// Backpressure: req_ready only in IDLE; requests wait on req_valid, NOP (cmd 0) is never accepted.
module c1_bus_master #(
    parameter int MEM_ADDR_SIZE     = 19,
    parameter int BUS_SIZE          = 16,
    parameter int CACHE_OFFSET_SIZE = 4,
    parameter int TIMEOUT_CYCLES    = 64
) (
    input  logic                                       clk,
    input  logic                                       rst_n,
    input  logic                                       req_valid,
    output logic                                       req_ready,
    input  logic [2:0]                                 req_cmd,
    input  logic [MEM_ADDR_SIZE-1:0]                   req_addr,
    input  logic [2*BUS_SIZE-1:0]                      req_wdata,
    output logic                                       resp_valid,
    output logic [2*BUS_SIZE-1:0]                      resp_rdata,
    output logic                                       resp_timeout,
    output logic                                       busy,
    output logic [MEM_ADDR_SIZE-CACHE_OFFSET_SIZE-1:0] address,
    inout  wire  [BUS_SIZE-1:0]                        data,
    inout  wire  [2:0]                                 command
);
    localparam int AW = MEM_ADDR_SIZE - CACHE_OFFSET_SIZE;
    localparam int DW = 2 * BUS_SIZE;
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [2:0] C_R8  = 3'd1;
    localparam logic [2:0] C_R16 = 3'd2;
    localparam logic [2:0] C_R32 = 3'd3;
    localparam logic [2:0] C_INV = 3'd4;
    localparam logic [2:0] C_W32 = 3'd7;
    localparam logic [2:0] C_RSP = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR1,
        S_ADDR2,
        S_WAIT,
        S_BEAT2,
        S_DONE
    } state_t;

    state_t                       r_state;
    logic                         r_req_ready;
    logic                         r_resp_valid;
    logic                         r_resp_timeout;
    logic [DW-1:0]                r_resp_rdata;
    logic [2:0]                   r_cmd;
    logic [CACHE_OFFSET_SIZE-1:0] r_off;
    logic [BUS_SIZE-1:0]          r_whi;
    logic [BUS_SIZE-1:0]          r_beat0;
    logic [CW-1:0]                r_cnt;
    logic                         r_bus_oe;
    logic                         r_data_oe;
    logic [AW-1:0]                r_addr_out;
    logic [BUS_SIZE-1:0]          r_data_out;

    logic                         w_resp;
    logic [CW:0]                  w_cnt_nxt;
    logic                         w_expired;

    // Only a clean 7 is a response; Z/X compare false.
    assign w_resp    = (command == C_RSP);
    assign w_cnt_nxt = {1'b0, r_cnt} + (CW+1)'(1);
    assign w_expired = (w_cnt_nxt >= (CW+1)'(TIMEOUT_CYCLES));

    assign req_ready    = r_req_ready;
    assign busy         = ~r_req_ready;
    assign resp_valid   = r_resp_valid;
    assign resp_timeout = r_resp_timeout;
    assign resp_rdata   = r_resp_rdata;

    assign address = r_bus_oe  ? r_addr_out : {AW{1'bz}};
    assign command = r_bus_oe  ? r_cmd      : 3'bzzz;
    assign data    = r_data_oe ? r_data_out : {BUS_SIZE{1'bz}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_req_ready    <= 1'b1;
            r_resp_valid   <= 1'b0;
            r_resp_timeout <= 1'b0;
            r_resp_rdata   <= '0;
            r_cmd          <= '0;
            r_off          <= '0;
            r_whi          <= '0;
            r_beat0        <= '0;
            r_cnt          <= '0;
            r_bus_oe       <= 1'b0;
            r_data_oe      <= 1'b0;
            r_addr_out     <= '0;
            r_data_out     <= '0;
        end else begin
            r_resp_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (req_valid && (req_cmd != 3'd0)) begin
                        r_state     <= S_ADDR1;
                        r_req_ready <= 1'b0;
                        r_cmd       <= req_cmd;
                        r_off       <= req_addr[CACHE_OFFSET_SIZE-1:0];
                        r_whi       <= req_wdata[DW-1:BUS_SIZE];
                        r_bus_oe    <= 1'b1;
                        r_addr_out  <= req_addr[MEM_ADDR_SIZE-1:CACHE_OFFSET_SIZE];
                        r_data_oe   <= req_cmd[2] && (req_cmd != C_INV);
                        r_data_out  <= req_wdata[BUS_SIZE-1:0];
                    end
                end
                S_ADDR1: begin
                    r_state    <= S_ADDR2;
                    r_addr_out <= AW'(r_off);
                    r_cnt      <= '0;
                    // Narrow writes keep beat0 on the bus for the second address cycle.
                    if (r_cmd == C_W32) begin
                        r_data_out <= r_whi;
                    end
                end
                S_ADDR2: begin
                    r_state   <= S_WAIT;
                    r_bus_oe  <= 1'b0;
                    r_data_oe <= 1'b0;
                end
                S_WAIT: begin
                    if (w_resp) begin
                        r_cnt <= w_cnt_nxt[CW-1:0];
                        if (r_cmd == C_R32) begin
                            r_beat0 <= data;
                            r_state <= S_BEAT2;
                        end else begin
                            r_state        <= S_DONE;
                            r_resp_valid   <= 1'b1;
                            r_resp_timeout <= 1'b0;
                            case (r_cmd)
                                C_R8:    r_resp_rdata <= DW'(data[7:0]);
                                C_R16:   r_resp_rdata <= DW'(data[15:0]);
                                default: r_resp_rdata <= '0;
                            endcase
                        end
                    end else if (w_expired) begin
                        r_state        <= S_DONE;
                        r_resp_valid   <= 1'b1;
                        r_resp_timeout <= 1'b1;
                        r_resp_rdata   <= '0;
                    end else begin
                        r_cnt <= w_cnt_nxt[CW-1:0];
                    end
                end
                S_BEAT2: begin
                    // The wait counter is shared with WAIT, so the whole response is bounded.
                    if (w_resp) begin
                        r_state        <= S_DONE;
                        r_resp_valid   <= 1'b1;
                        r_resp_timeout <= 1'b0;
                        r_resp_rdata   <= {data, r_beat0};
                    end else if (w_expired) begin
                        r_state        <= S_DONE;
                        r_resp_valid   <= 1'b1;
                        r_resp_timeout <= 1'b1;
                        r_resp_rdata   <= '0;
                    end else begin
                        r_cnt <= w_cnt_nxt[CW-1:0];
                    end
                end
                S_DONE: begin
                    r_state        <= S_IDLE;
                    r_req_ready    <= 1'b1;
                    r_resp_timeout <= 1'b0;
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_req_ready <= 1'b1;
                    r_bus_oe    <= 1'b0;
                    r_data_oe   <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_c1_bus_master.sv
// Bench for c1_bus_master: directed C1 scenarios plus randomized transactions against a cycle-level reference model.
module tb_c1_bus_master;
    localparam int MAS = 19;
    localparam int BUS = 16;
    localparam int COS = 4;
    localparam int TMO = 8;
    localparam logic [14:0] ADDR_Z = 15'h7FFF;
    localparam logic [15:0] DATA_Z = 16'hFFFF;
    localparam logic [2:0]  CMD_Z  = 3'd0;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic [2:0]  req_cmd;
    logic [18:0] req_addr;
    logic [31:0] req_wdata;
    wire         req_ready;
    wire         resp_valid;
    wire  [31:0] resp_rdata;
    wire         resp_timeout;
    wire         busy;
    tri1  [14:0] address;
    tri1  [15:0] data;
    tri0  [2:0]  command;

    logic        tb_cmd_en;
    logic [2:0]  tb_cmd_val;
    logic        tb_data_en;
    logic [15:0] tb_data;

    int n_cmp = 0;
    int n_err = 0;

    assign command = tb_cmd_en  ? tb_cmd_val : 3'bzzz;
    assign data    = tb_data_en ? tb_data    : 16'hzzzz;

    c1_bus_master #(
        .MEM_ADDR_SIZE    (MAS),
        .BUS_SIZE         (BUS),
        .CACHE_OFFSET_SIZE(COS),
        .TIMEOUT_CYCLES   (TMO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_cmd     (req_cmd),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .resp_valid  (resp_valid),
        .resp_rdata  (resp_rdata),
        .resp_timeout(resp_timeout),
        .busy        (busy),
        .address     (address),
        .data        (data),
        .command     (command)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Read data as the core should see it, by size.
    function automatic logic [31:0] exp_read(input logic [2:0] cmd, input logic [15:0] d0, input logic [15:0] d1);
        case (cmd)
            3'd1:    return {24'h0, d0[7:0]};
            3'd2:    return {16'h0, d0};
            3'd3:    return {d1, d0};
            default: return 32'h0;
        endcase
    endfunction

    // Cycle 1 = first cycle after the accepting edge; the slave's wait index k is cycle 3+k.
    task automatic run_txn(input logic [2:0] cmd, input logic [18:0] addr, input logic [31:0] wd,
                           input int waits, input int b2w, input bit no_resp,
                           input logic [15:0] d0, input logic [15:0] d1, input bit keep_valid);
        int          exp_done, got_done, pulses, idx;
        logic [31:0] exp_rd, got_rd;
        logic        exp_to, got_to;
        bit          prev_drv, drv;
        logic [15:0] exp_d1, exp_d2;
        logic [14:0] exp_a2;
        if (no_resp || (cmd == 3'd3 && waits + 1 + b2w >= TMO)) begin
            exp_done = 3 + TMO;
            exp_rd   = 32'h0;
            exp_to   = 1'b1;
        end else begin
            exp_done = 3 + waits + 1 + ((cmd == 3'd3) ? b2w + 1 : 0);
            exp_rd   = exp_read(cmd, d0, d1);
            exp_to   = 1'b0;
        end
        exp_d1 = (cmd >= 3'd5) ? wd[15:0] : DATA_Z;
        exp_d2 = (cmd == 3'd7) ? wd[31:16] : exp_d1;
        exp_a2 = {11'h0, addr[3:0]};

        check("ready_before", req_ready, 1'b1);
        req_valid = 1'b1;
        req_cmd   = cmd;
        req_addr  = addr;
        req_wdata = wd;
        step();
        if (!keep_valid) begin
            req_valid = 1'b0;
            req_cmd   = 3'($urandom);
            req_addr  = 19'($urandom);
            req_wdata = $urandom;
        end
        check("a1_cmd", command, cmd);
        check("a1_addr", address, addr[18:4]);
        check("a1_data", data, exp_d1);
        check("a1_busy", busy, 1'b1);
        step();
        check("a2_cmd", command, cmd);
        check("a2_addr", address, exp_a2);
        check("a2_data", data, exp_d2);

        got_done = 0;
        pulses   = 0;
        got_rd   = 32'h0;
        got_to   = 1'b0;
        prev_drv = 1'b0;
        for (int rel = 3; rel <= 3 + TMO + 6; rel++) begin
            step();
            check("wait_addr_z", address, ADDR_Z);
            if (!prev_drv) begin
                check("wait_cmd_z", command, CMD_Z);
                check("wait_data_z", data, DATA_Z);
            end
            if (resp_valid === 1'b1) begin
                pulses++;
                if (got_done == 0) begin
                    got_done = rel;
                    got_rd   = resp_rdata;
                    got_to   = resp_timeout;
                    check("ready_in_done", req_ready, 1'b0);
                end
            end
            if (got_done != 0 && rel == got_done + 1) begin
                check("rdata_hold", resp_rdata, exp_rd);
                check("ready_after", req_ready, 1'b1);
                break;
            end
            idx = rel - 3;
            drv = !no_resp && (idx == waits || (cmd == 3'd3 && idx == waits + 1 + b2w));
            tb_cmd_val = 3'd7;
            tb_cmd_en  = drv;
            tb_data_en = drv;
            tb_data    = (idx == waits) ? d0 : d1;
            // Non-7 command noise while the slave is still waiting must be ignored.
            if (!drv && idx < waits && $urandom_range(0, 1) == 1) begin
                tb_cmd_en  = 1'b1;
                tb_cmd_val = 3'($urandom_range(0, 6));
                drv        = 1'b1;
            end
            prev_drv = drv;
        end
        tb_cmd_en  = 1'b0;
        tb_data_en = 1'b0;
        check("done_cycle", got_done, exp_done);
        check("resp_pulses", pulses, 1);
        check("resp_rdata", got_rd, exp_rd);
        check("resp_timeout", got_to, exp_to);
    endtask

    task automatic reset_mid(input logic [2:0] cmd, input int at_cycle);
        req_valid = 1'b1;
        req_cmd   = cmd;
        req_addr  = 19'h12345;
        req_wdata = 32'h1357_2468;
        step();
        req_valid = 1'b0;
        for (int c = 1; c < at_cycle; c++) step();
        rst_n = 1'b0;
        #1;
        check("rst_addr_z", address, ADDR_Z);
        check("rst_data_z", data, DATA_Z);
        check("rst_cmd_z", command, CMD_Z);
        check("rst_ready", req_ready, 1'b1);
        check("rst_no_resp", resp_valid, 1'b0);
        step();
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            step();
            check("post_rst_no_resp", resp_valid, 1'b0);
        end
        check("post_rst_ready", req_ready, 1'b1);
    endtask

    initial begin
        logic [2:0]  cmd;
        logic [18:0] addr;
        logic [31:0] wd;
        logic [15:0] d0, d1;
        int          waits, b2w;
        bit          nr;

        rst_n      = 1'b1;
        req_valid  = 1'b0;
        req_cmd    = 3'd0;
        req_addr   = 19'h0;
        req_wdata  = 32'h0;
        tb_cmd_en  = 1'b0;
        tb_cmd_val = 3'd0;
        tb_data_en = 1'b0;
        tb_data    = 16'h0;
        #1 rst_n = 1'b0;
        #2;
        check("reset_ready", req_ready, 1'b1);
        check("reset_busy", busy, 1'b0);
        check("reset_valid", resp_valid, 1'b0);
        check("reset_timeout", resp_timeout, 1'b0);
        check("reset_rdata", resp_rdata, 32'h0);
        check("reset_addr_z", address, ADDR_Z);
        check("reset_data_z", data, DATA_Z);
        check("reset_cmd_z", command, CMD_Z);
        step();
        step();
        rst_n = 1'b1;
        step();

        // NOP with valid held is never accepted.
        req_valid = 1'b1;
        req_cmd   = 3'd0;
        for (int c = 0; c < 5; c++) begin
            step();
            check("nop_ready", req_ready, 1'b1);
            check("nop_cmd_z", command, CMD_Z);
            check("nop_no_resp", resp_valid, 1'b0);
        end
        req_valid = 1'b0;

        run_txn(3'd6, 19'b0000000000_00010_0010, 32'h0000_5555, 3, 0, 1'b0, 16'h0, 16'h0, 1'b0);
        run_txn(3'd3, 19'b0000000000_00010_0000, 32'h0, 0, 0, 1'b0, 16'hAAAA, 16'h1234, 1'b0);
        run_txn(3'd1, 19'h2_1A37, 32'h0, 1, 0, 1'b0, 16'hBEEF, 16'h0, 1'b0);
        run_txn(3'd7, 19'h0_4C21, 32'hCAFE_F00D, 1, 0, 1'b0, 16'h0, 16'h0, 1'b0);
        run_txn(3'd2, 19'h7_0F0F, 32'h0, 0, 0, 1'b1, 16'h0, 16'h0, 1'b0);
        run_txn(3'd2, 19'h1_2222, 32'h0, 2, 0, 1'b0, 16'h9876, 16'h0, 1'b0);
        run_txn(3'd3, 19'h3_3330, 32'h0, 2, 100, 1'b0, 16'h4444, 16'h5555, 1'b0);
        run_txn(3'd1, 19'h0_0001, 32'h0, TMO - 1, 0, 1'b0, 16'h00A5, 16'h0, 1'b0);

        reset_mid(3'd2, 3);
        reset_mid(3'd7, 1);

        // Back-to-back: valid held through the first transaction.
        run_txn(3'd5, 19'h5_5550, 32'h0000_00C3, 0, 0, 1'b0, 16'h0, 16'h0, 1'b1);
        run_txn(3'd4, 19'h6_6660, 32'h0, 1, 0, 1'b0, 16'h0, 16'h0, 1'b0);

        for (int t = 0; t < 40; t++) begin
            cmd   = 3'($urandom_range(1, 7));
            addr  = 19'($urandom);
            wd    = $urandom;
            d0    = 16'($urandom);
            d1    = 16'($urandom);
            waits = $urandom_range(0, 3);
            b2w   = $urandom_range(0, 2);
            nr    = ($urandom_range(0, 7) == 0);
            run_txn(cmd, addr, wd, waits, b2w, nr, d0, d1, 1'b0);
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
